// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the RAM-port arbiter and its
//            byte sequencer.
// Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IF_READ   = 3'd1,
    ST_MEM_READ  = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Width of one RAM transfer.
  localparam int RAM_W = 8;

  // Byte counts carried on mem_len.
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // A fetch miss always reads a full word; the last capture happens at cnt==4.
  localparam logic [2:0] IF_LAST_CNT = LEN_W;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_byte_seq.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_seq
// Purpose  : Byte counter, address increment, little-endian read assembly
//            and store-byte selection for the byte-wide RAM port.
// Revision : 1.0  initial release
// ============================================================================
module mem_byte_seq
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,    // load base/wdata/init, clear cnt
  input  logic [31:0]      base_i,
  input  logic [31:0]      wdata_i,
  input  logic [31:0]      init_i,     // initial assembly word (hit data or 0)
  input  logic             run_i,      // in a transfer state: advance cnt
  input  logic             capture_i,  // read transfer: store returning bytes
  input  logic [RAM_W-1:0] rdbyte_i,
  output logic [2:0]       cnt_o,
  output logic [31:0]      base_o,
  output logic [31:0]      addr_o,
  output logic [31:0]      word_o,
  output logic [RAM_W-1:0] wbyte_o
);

  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;
  logic [2:0]  cnt_q;
  logic [1:0]  lane;

  // The byte arriving now was addressed last cycle, i.e. at cnt-1.
  assign lane = cnt_q[1:0] - 2'd1;

  // Latch the transfer context on start, then count and assemble bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q  <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
      word_q  <= ZERO_WORD;
      cnt_q   <= 3'd0;
    end else if (start_i) begin
      base_q  <= base_i;
      wdata_q <= wdata_i;
      word_q  <= init_i;
      cnt_q   <= 3'd0;
    end else if (run_i) begin
      cnt_q <= cnt_q + 3'd1;
      if (capture_i && (cnt_q != 3'd0)) begin
        word_q[{lane, 3'b000} +: RAM_W] <= rdbyte_i;
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign base_o  = base_q;
  assign addr_o  = base_q + {29'd0, cnt_q};   // wraps modulo 2^32
  assign word_o  = word_q;
  assign wbyte_o = wdata_q[{cnt_q[1:0], 3'b000} +: RAM_W];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Arbitrates the byte-wide RAM port between instruction fetch and
//            data accesses, and controls the direct-mapped I-cache lookup
//            and fill. Data requests win over fetches.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  // instruction fetch
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  input  logic             if_flush,
  output logic             if_done,
  output logic [31:0]      if_inst,
  // data access
  input  logic             mem_req,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [2:0]       mem_len,
  input  logic [31:0]      mem_wdata,
  output logic             mem_done,
  output logic [31:0]      mem_rdata,
  // instruction cache
  output logic             cache_query,
  output logic [31:0]      query_addr,
  input  logic             cache_hit,
  input  logic [31:0]      cache_inst,
  output logic             cache_enable,
  output logic [31:0]      fill_addr,
  output logic [31:0]      fill_data,
  // RAM port
  output logic [31:0]      ram_addr,
  output logic [RAM_W-1:0] ram_din,
  output logic             ram_wr,
  input  logic [RAM_W-1:0] ram_dout
);

  state_t      state_q;
  logic [2:0]  len_q;
  logic        fetch_q;   // current transaction belongs to the fetch side
  logic        fill_q;    // fetch was a miss: fill the cache on response

  logic             accept;
  logic             run;
  logic             capture;
  logic             resp;
  logic [2:0]       seq_cnt;
  logic [31:0]      seq_base;
  logic [31:0]      seq_addr;
  logic [31:0]      seq_word;
  logic [RAM_W-1:0] seq_wbyte;

  // A fetch is looked up only when no data request competes and it is not
  // being flushed this cycle.
  assign cache_query = (state_q == ST_IDLE) && !mem_req && if_req && !if_flush;
  assign query_addr  = cache_query ? if_addr : ZERO_WORD;

  assign accept  = (state_q == ST_IDLE) && (mem_req || cache_query);
  assign run     = (state_q == ST_IF_READ) || (state_q == ST_MEM_READ) ||
                   (state_q == ST_MEM_WRITE);
  assign capture = (state_q == ST_IF_READ) || (state_q == ST_MEM_READ);
  assign resp    = (state_q == ST_RESP);

  mem_byte_seq u_seq (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept),
    .base_i    (mem_req ? mem_addr : if_addr),
    .wdata_i   (mem_wdata),
    .init_i    ((cache_query && cache_hit) ? cache_inst : ZERO_WORD),
    .run_i     (run),
    .capture_i (capture),
    .rdbyte_i  (ram_dout),
    .cnt_o     (seq_cnt),
    .base_o    (seq_base),
    .addr_o    (seq_addr),
    .word_o    (seq_word),
    .wbyte_o   (seq_wbyte)
  );

  // Arbitration and transfer sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= 3'd0;
      fetch_q <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_req) begin
            len_q   <= mem_len;
            fetch_q <= 1'b0;
            fill_q  <= 1'b0;
            state_q <= mem_we ? ST_MEM_WRITE : ST_MEM_READ;
          end else if (cache_query) begin
            fetch_q <= 1'b1;
            fill_q  <= !cache_hit;
            state_q <= cache_hit ? ST_RESP : ST_IF_READ;
          end
        end
        ST_IF_READ: begin
          if (if_flush)                    state_q <= ST_IDLE;
          else if (seq_cnt == IF_LAST_CNT) state_q <= ST_RESP;
        end
        ST_MEM_READ: begin
          if (seq_cnt == len_q) state_q <= ST_RESP;
        end
        ST_MEM_WRITE: begin
          if (seq_cnt == len_q - 3'd1) state_q <= ST_RESP;
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // A flush in the fetch response cycle cancels both the done and the fill.
  assign if_done      = resp && fetch_q && !if_flush;
  assign mem_done     = resp && !fetch_q;
  assign if_inst      = if_done  ? seq_word : ZERO_WORD;
  assign mem_rdata    = mem_done ? seq_word : ZERO_WORD;
  assign cache_enable = if_done && fill_q;
  assign fill_addr    = cache_enable ? seq_base : ZERO_WORD;
  assign fill_data    = cache_enable ? seq_word : ZERO_WORD;

  assign ram_wr   = (state_q == ST_MEM_WRITE);
  assign ram_addr = run ? seq_addr : ZERO_WORD;
  assign ram_din  = ram_wr ? seq_wbyte : {RAM_W{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with RAM and I-cache models.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_len;
  logic        cache_query, cache_hit, cache_enable;
  logic [31:0] query_addr, cache_inst, fill_addr, fill_data;
  logic [31:0] ram_addr;
  logic [7:0]  ram_din, ram_dout;
  logic        ram_wr;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .cache_query(cache_query), .query_addr(query_addr),
    .cache_hit(cache_hit), .cache_inst(cache_inst),
    .cache_enable(cache_enable), .fill_addr(fill_addr), .fill_data(fill_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr), .ram_dout(ram_dout)
  );

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model (8 KiB, registered read) ----------------
  logic [7:0] ram [0:8191];

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      32'h200: return 8'h13;  32'h201: return 8'h05;
      32'h202: return 8'h10;  32'h203: return 8'h00;
      32'h300: return 8'h93;  32'h301: return 8'h00;
      32'h302: return 8'h10;  32'h303: return 8'h00;
      32'h400: return 8'h01;  32'h401: return 8'h02;
      32'h402: return 8'h03;  32'h403: return 8'h04;
      32'h1000: return 8'h11; 32'h1001: return 8'h22;
      32'h1002: return 8'h33; 32'h1003: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 8192; i++) ram[i] <= init_byte(i);
    end else if (ram_wr) begin
      ram[ram_addr[12:0]] <= ram_din;
    end
    ram_dout <= ram[ram_addr[12:0]];
  end

  // ---------------- I-cache model (256 entries, full-address tag) -------
  logic        cvalid [0:255];
  logic [31:0] ctag   [0:255];
  logic [31:0] cdata  [0:255];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) cvalid[i] <= 1'b0;
      cvalid[8'h40] <= 1'b1;
      ctag[8'h40]   <= 32'h100;
      cdata[8'h40]  <= 32'h00A00093;
    end else if (cache_enable) begin
      cvalid[fill_addr[9:2]] <= 1'b1;
      ctag[fill_addr[9:2]]   <= fill_addr;
      cdata[fill_addr[9:2]]  <= fill_data;
    end
  end

  always_comb begin
    cache_hit  = cache_query && (cvalid[query_addr[9:2]] === 1'b1) &&
                 (ctag[query_addr[9:2]] == query_addr);
    cache_inst = cdata[query_addr[9:2]];
  end

  // ---------------- scoreboard ----------------
  typedef struct { bit is_if; int cyc; logic [31:0] data; bit fill; logic [31:0] faddr; } done_t;
  typedef struct { int cyc; logic [31:0] addr; bit we; logic [7:0] din; } acc_t;
  done_t done_q[$];
  acc_t  acc_q[$];
  done_t d;
  acc_t  a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic exp_reads(input int t, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) acc_q.push_back('{t + 1 + k, base + 32'(k), 1'b0, 8'h00});
  endtask

  task automatic exp_write(input int c, input logic [31:0] ad, input logic [7:0] din);
    acc_q.push_back('{c, ad, 1'b1, din});
  endtask

  // Monitor: compares RAM-port activity and every done pulse to expectations.
  always @(negedge clk) begin
    if (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
      chk("ram_access_cycle", 32'(cyc), 32'(acc_q[0].cyc));
      void'(acc_q.pop_front());
    end
    if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
      a = acc_q.pop_front();
      chk("ram_addr", ram_addr, a.addr);
      chk("ram_wr", 32'(ram_wr), 32'(a.we));
      if (a.we) chk("ram_din", 32'(ram_din), 32'(a.din));
    end else if (ram_wr === 1'b1) begin
      flag("unexpected_ram_wr");
    end
    if (if_done === 1'b1 || mem_done === 1'b1) begin
      if (done_q.size() == 0) begin
        flag("unexpected_done");
      end else begin
        d = done_q.pop_front();
        chk("done_kind", 32'(if_done), 32'(d.is_if));
        chk("done_cycle", 32'(cyc), 32'(d.cyc));
        chk("done_data", (if_done === 1'b1) ? if_inst : mem_rdata, d.data);
        chk("cache_enable", 32'(cache_enable), 32'(d.fill));
        if (d.fill) begin
          chk("fill_addr", fill_addr, d.faddr);
          chk("fill_data", fill_data, d.data);
        end
      end
    end else if (cache_enable === 1'b1) begin
      flag("unexpected_cache_enable");
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit want_if);
    int n = 0;
    while (n < 60) begin
      @(negedge clk);
      if (want_if ? (if_done === 1'b1) : (mem_done === 1'b1)) break;
      n++;
    end
    if (n >= 60) flag(want_if ? "timeout_if_done" : "timeout_mem_done");
    step();
  endtask

  task automatic chk_outputs_zero(input string tag);
    @(negedge clk);
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'h0);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_din"}, 32'(ram_din), 32'h0);
    chk({tag, "_if_done"}, 32'(if_done), 32'h0);
    chk({tag, "_mem_done"}, 32'(mem_done), 32'h0);
    chk({tag, "_cache_enable"}, 32'(cache_enable), 32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'h0);
    chk({tag, "_fill_addr"}, fill_addr, 32'h0);
  endtask

  task automatic mem_op(input bit we, input logic [31:0] ad, input logic [2:0] len,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
    int t = cyc;
    mem_req = 1'b1; mem_we = we; mem_addr = ad; mem_len = len; mem_wdata = wd;
    if (we) begin
      for (int k = 0; k < int'(len); k++) exp_write(t + 1 + k, ad + 32'(k), wd[8*k +: 8]);
      done_q.push_back('{1'b0, t + int'(len) + 1, exp_rd, 1'b0, 32'h0});
    end else begin
      exp_reads(t, ad, int'(len));
      done_q.push_back('{1'b0, t + int'(len) + 2, exp_rd, 1'b0, 32'h0});
    end
    wait_done(1'b0);
    mem_req = 1'b0; mem_we = 1'b0;
  endtask

  task automatic fetch_miss(input logic [31:0] ad, input logic [31:0] word);
    int t = cyc;
    if_req = 1'b1; if_addr = ad;
    exp_reads(t, ad, 4);
    done_q.push_back('{1'b1, t + 6, word, 1'b1, ad});
    wait_done(1'b1);
    if_req = 1'b0;
  endtask

  task automatic fetch_hit(input logic [31:0] ad, input logic [31:0] word);
    int t = cyc;
    if_req = 1'b1; if_addr = ad;
    done_q.push_back('{1'b1, t + 1, word, 1'b0, 32'h0});
    @(negedge clk);
    chk("cache_query", 32'(cache_query), 32'h1);
    chk("query_addr", query_addr, ad);
    wait_done(1'b1);
    if_req = 1'b0;
  endtask

  initial begin
    int t;
    if_req = 0; if_addr = 0; if_flush = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0; mem_len = 0; mem_wdata = 0;
    repeat (3) step();
    rst = 1'b0;
    chk_outputs_zero("reset");
    step();

    // Fetch hit and fetch miss, then a hit on the freshly filled line.
    fetch_hit(32'h100, 32'h00A00093);
    fetch_miss(32'h200, 32'h00100513);
    fetch_hit(32'h200, 32'h00100513);

    // Contention: data load wins, fetch starts once the block is idle again.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h300;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h1000; mem_len = 3'd4;
    exp_reads(t, 32'h1000, 4);
    done_q.push_back('{1'b0, t + 6, 32'h44332211, 1'b0, 32'h0});
    exp_reads(t + 7, 32'h300, 4);
    done_q.push_back('{1'b1, t + 13, 32'h00100093, 1'b1, 32'h300});
    wait_done(1'b0);
    mem_req = 1'b0;
    wait_done(1'b1);
    if_req = 1'b0;

    // Halfword store, then read it back as halfword and as single byte.
    mem_op(1'b1, 32'h1004, 3'd2, 32'h0000BEEF, 32'h0);
    mem_op(1'b0, 32'h1004, 3'd2, 32'h0, 32'h0000BEEF);
    mem_op(1'b0, 32'h1005, 3'd1, 32'h0, 32'h000000BE);

    // Flush at T+3 of a miss: back to idle at T+4, no done and no fill.
    t = cyc;
    if_req = 1'b1; if_addr = 32'h400;
    exp_reads(t, 32'h400, 3);
    repeat (3) step();
    if_flush = 1'b1; if_req = 1'b0;
    step();
    if_flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_ram_addr", ram_addr, 32'h0);
    repeat (8) step();
    fetch_miss(32'h400, 32'h04030201);

    // Reset during cycle T+2 of a word store: two bytes land, no done.
    t = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h1100; mem_len = 3'd4;
    mem_wdata = 32'hCAFEF00D;
    exp_write(t + 1, 32'h1100, 8'h0D);
    exp_write(t + 2, 32'h1101, 8'hF0);
    repeat (2) step();
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    step();
    rst = 1'b0;
    chk_outputs_zero("midreset");
    repeat (5) step();
    mem_op(1'b0, 32'h1100, 3'd4, 32'h0, 32'h0000F00D);

    repeat (5) step();
    chk("done_queue_left", 32'(done_q.size()), 32'h0);
    chk("access_queue_left", 32'(acc_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
